// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - period / high-time meter for a slow external square wave.
// Define FREQ_METER_HIGH_EN to build the high-time counter; otherwise high_time is tied to 0.
module freq_meter #(
    parameter int CNT_BIT = 26,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sig_in,
    output logic [CNT_BIT-1:0] period,
    output logic [CNT_BIT-1:0] high_time,
    output logic               valid,
    output logic               timeout,
    output logic               busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_BIT-1:0] TMO = CNT_BIT'(TIMEOUT);
    localparam logic [CNT_BIT-1:0] ONE = CNT_BIT'(1);

    state_t             state_q;
    logic               s1_q, s2_q, s3_q;
    logic [CNT_BIT-1:0] cnt_q, cnt_d;
    logic [CNT_BIT-1:0] period_q;
    logic               valid_q, timeout_q, busy_q;
    logic               rise, start, publish, expire, counting;

    assign rise     = s2_q & ~s3_q;
    assign start    = en & (state_q == IDLE) & rise;
    assign publish  = en & (state_q == MEASURE) & rise;
    // A rise landing on cnt == TIMEOUT is still a valid measurement.
    assign expire   = en & (state_q == MEASURE) & ~rise & (cnt_q == TMO);
    assign counting = en & (state_q == MEASURE) & ~rise & ~expire;

    always_comb begin
        cnt_d = '0;
        if (start || publish) begin
            cnt_d = ONE;
        end else if (counting) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            s1_q      <= sig_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            cnt_q     <= cnt_d;
            valid_q   <= publish;
            timeout_q <= expire;
            if (publish) begin
                period_q <= cnt_q;
            end
            if (!en) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= MEASURE;
                            busy_q  <= 1'b1;
                        end
                    end
                    MEASURE: begin
                        if (expire) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FREQ_METER_HIGH_EN
    logic [CNT_BIT-1:0] hi_q, hi_d, high_q;

    // The rise cycle itself is high, hence the restart value of 1.
    always_comb begin
        hi_d = '0;
        if (start || publish) begin
            hi_d = ONE;
        end else if (counting) begin
            hi_d = hi_q + CNT_BIT'(s2_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            high_q <= '0;
        end else begin
            hi_q <= hi_d;
            if (publish) begin
                high_q <= hi_q;
            end
        end
    end

    assign high_time = high_q;
`else
    assign high_time = '0;
`endif

    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed bench for freq_meter (instances with TIMEOUT 100 and 20).
module tb_freq_meter;

    localparam int CNT_BIT = 26;
`ifdef FREQ_METER_HIGH_EN
    localparam bit HIGH_EN = 1'b1;
`else
    localparam bit HIGH_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic sig_in = 1'b0;
    logic [CNT_BIT-1:0] period_a, high_a, period_b, high_b;
    logic valid_a, timeout_a, busy_a, valid_b, timeout_b, busy_b;

    always #5 clk = ~clk;

    freq_meter #(.CNT_BIT(CNT_BIT), .TIMEOUT(100)) dut_a (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .period(period_a), .high_time(high_a), .valid(valid_a),
        .timeout(timeout_a), .busy(busy_a)
    );

    freq_meter #(.CNT_BIT(CNT_BIT), .TIMEOUT(20)) dut_b (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .period(period_b), .high_time(high_b), .valid(valid_b),
        .timeout(timeout_b), .busy(busy_b)
    );

    int exp_p = -1;
    int exp_h = -1;

    int cyc = 0, va = 0, ta = 0, vb = 0, tbn = 0, bad = 0, pair = 0, wide = 0;
    int last_vc = 0, prev_vc = 0, last_to = 0;
    logic valid_prev = 1'b0;

    // Event monitor: counts strobes and flags any published value that disagrees with exp_p/exp_h.
    always @(negedge clk) begin
        cyc        <= cyc + 1;
        valid_prev <= valid_a;
        if (valid_a) begin
            va      <= va + 1;
            prev_vc <= last_vc;
            last_vc <= cyc;
            if ((exp_p >= 0 && int'(period_a) != exp_p) || (exp_h >= 0 && int'(high_a) != exp_h))
                bad <= bad + 1;
        end
        if (timeout_a) begin
            ta      <= ta + 1;
            last_to <= cyc;
        end
        if (valid_a && timeout_a) pair <= pair + 1;
        if (valid_a && valid_prev) wide <= wide + 1;
        if (valid_b) vb <= vb + 1;
        if (timeout_b) tbn <= tbn + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input int n);
        sig_in = v;
        tick(n);
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        repeat (reps) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        sig_in = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_p;
        int exp_h;
        int exp_v;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int b_va, b_ta, b_vb, b_tb, b_bad, mid;

        vecs[0] = '{hi: 5,  lo: 5,  reps: 6, exp_p: 10,  exp_h: 5,  exp_v: 5};
        vecs[1] = '{hi: 3,  lo: 13, reps: 4, exp_p: 16,  exp_h: 3,  exp_v: 3};
        vecs[2] = '{hi: 12, lo: 4,  reps: 4, exp_p: 16,  exp_h: 12, exp_v: 3};
        vecs[3] = '{hi: 1,  lo: 1,  reps: 6, exp_p: 2,   exp_h: 1,  exp_v: 5};
        vecs[4] = '{hi: 2,  lo: 1,  reps: 5, exp_p: 3,   exp_h: 2,  exp_v: 4};
        vecs[5] = '{hi: 40, lo: 59, reps: 3, exp_p: 99,  exp_h: 40, exp_v: 2};
        vecs[6] = '{hi: 50, lo: 50, reps: 3, exp_p: 100, exp_h: 50, exp_v: 2};

        // Reset state
        tick(3);
        chk("rst_period", 64'(period_a), 64'd0);
        chk("rst_high", 64'(high_a), 64'd0);
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_timeout", 64'(timeout_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            en    = 1'b1;
            exp_p = vecs[i].exp_p;
            exp_h = HIGH_EN ? vecs[i].exp_h : 0;
            b_va  = va;
            b_ta  = ta;
            b_bad = bad;
            wave(vecs[i].hi, vecs[i].lo, vecs[i].reps);
            drive(1'b0, 2);
            chk($sformatf("vec%0d_valids", i), 64'(va - b_va), 64'(vecs[i].exp_v));
            chk($sformatf("vec%0d_timeouts", i), 64'(ta - b_ta), 64'd0);
            chk($sformatf("vec%0d_bad_values", i), 64'(bad - b_bad), 64'd0);
            chk($sformatf("vec%0d_period", i), 64'(period_a), 64'(vecs[i].exp_p));
            chk($sformatf("vec%0d_high", i), 64'(high_a), 64'(exp_h));
            chk($sformatf("vec%0d_cadence", i), 64'(last_vc - prev_vc), 64'(vecs[i].hi + vecs[i].lo));
            chk($sformatf("vec%0d_busy", i), 64'(busy_a), 64'd1);
        end

        // Reset in the middle of a measurement
        do_reset();
        en    = 1'b1;
        exp_p = 10;
        exp_h = HIGH_EN ? 5 : 0;
        wave(5, 5, 2);
        drive(1'b1, 5);
        rst = 1'b1;
        drive(1'b0, 2);
        chk("midrst_period", 64'(period_a), 64'd0);
        chk("midrst_high", 64'(high_a), 64'd0);
        chk("midrst_valid", 64'(valid_a), 64'd0);
        chk("midrst_timeout", 64'(timeout_a), 64'd0);
        chk("midrst_busy", 64'(busy_a), 64'd0);
        rst  = 1'b0;
        b_va = va;
        drive(1'b0, 3);
        wave(5, 5, 2);
        drive(1'b1, 3);
        drive(1'b0, 2);
        chk("midrst_valids_after", 64'(va - b_va), 64'd2);
        chk("midrst_period_after", 64'(period_a), 64'd10);

        // Duty change at constant period
        do_reset();
        en    = 1'b1;
        exp_p = 16;
        exp_h = -1;
        b_bad = bad;
        wave(3, 13, 3);
        drive(1'b1, 4);
        chk("duty_a_period", 64'(period_a), 64'd16);
        chk("duty_a_high", 64'(high_a), HIGH_EN ? 64'd3 : 64'd0);
        drive(1'b1, 8);
        drive(1'b0, 4);
        drive(1'b1, 4);
        chk("duty_b_period", 64'(period_a), 64'd16);
        chk("duty_b_high", 64'(high_a), HIGH_EN ? 64'd12 : 64'd0);
        chk("duty_bad_values", 64'(bad - b_bad), 64'd0);

        // Timeout after the input stops toggling
        do_reset();
        en    = 1'b1;
        exp_p = 10;
        exp_h = HIGH_EN ? 5 : 0;
        b_va  = va;
        b_ta  = ta;
        wave(5, 5, 3);
        drive(1'b1, 5);
        drive(1'b0, 120);
        chk("tmo_valids", 64'(va - b_va), 64'd3);
        chk("tmo_count", 64'(ta - b_ta), 64'd1);
        chk("tmo_delay", 64'(last_to - last_vc), 64'd100);
        chk("tmo_busy", 64'(busy_a), 64'd0);
        chk("tmo_period_kept", 64'(period_a), 64'd10);

        // Boundary: period equal to TIMEOUT is published, one longer times out
        do_reset();
        en    = 1'b1;
        exp_p = 20;
        exp_h = HIGH_EN ? 10 : 0;
        b_vb  = vb;
        b_tb  = tbn;
        wave(10, 10, 4);
        drive(1'b1, 3);
        drive(1'b0, 2);
        chk("bnd20_valids", 64'(vb - b_vb), 64'd4);
        chk("bnd20_timeouts", 64'(tbn - b_tb), 64'd0);
        chk("bnd20_period", 64'(period_b), 64'd20);
        do_reset();
        en    = 1'b1;
        exp_p = 21;
        b_vb  = vb;
        b_tb  = tbn;
        b_va  = va;
        wave(10, 11, 4);
        drive(1'b1, 3);
        drive(1'b0, 2);
        chk("bnd21_valids", 64'(vb - b_vb), 64'd0);
        chk("bnd21_timeouts", 64'(tbn - b_tb), 64'd4);
        chk("bnd21_period_kept", 64'(period_b), 64'd0);
        chk("bnd21_ref_valids", 64'(va - b_va), 64'd4);
        chk("bnd21_ref_period", 64'(period_a), 64'd21);

        // Enable gating
        do_reset();
        en    = 1'b1;
        exp_p = 10;
        exp_h = HIGH_EN ? 5 : 0;
        b_va  = va;
        wave(5, 5, 3);
        drive(1'b1, 3);
        en = 1'b0;
        drive(1'b1, 2);
        mid = va;
        chk("en_valids_before", 64'(mid - b_va), 64'd3);
        drive(1'b0, 5);
        wave(5, 5, 2);
        drive(1'b1, 3);
        chk("en_low_valids", 64'(va - mid), 64'd0);
        chk("en_low_busy", 64'(busy_a), 64'd0);
        en  = 1'b1;
        mid = va;
        drive(1'b1, 2);
        drive(1'b0, 5);
        drive(1'b1, 5);
        chk("en_first_rise_valids", 64'(va - mid), 64'd0);
        drive(1'b0, 5);
        wave(5, 5, 1);
        drive(1'b1, 3);
        drive(1'b0, 2);
        chk("en_valids_after", 64'(va - mid), 64'd2);
        chk("en_period_after", 64'(period_a), 64'd10);

        chk("valid_timeout_overlap", 64'(pair), 64'd0);
        chk("valid_wider_than_1", 64'(wide), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Measures the period and high time of a slow external square wave, in `clk` cycles. The input is synchronized, and each period is timed from one rising edge to the next. Results are published with a one-cycle valid strobe. It is the receiving end of the team's clock dividers: it turns a divided or external clock back into a cycle count for display or self-check logic.

## Interface
- `CNT_BIT`, 26: width of the period and high-time counters and outputs.
- `TIMEOUT`, 50_000_000: maximum period counted before the measurement is abandoned; must be less than 2^`CNT_BIT`.

- `clk`  input  1  global clock; all logic on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  measurement enable; low forces IDLE.
- `sig_in`  input  1  asynchronous square wave under test.
- `period`  output  `CNT_BIT`  last measured period in `clk` cycles.
- `high_time`  output  `CNT_BIT`  high cycles within that period (see Configuration).
- `valid`  output  1  one-cycle pulse when `period`/`high_time` update.
- `timeout`  output  1  one-cycle pulse when a measurement is abandoned.
- `busy`  output  1  high while in MEASURE.

## Operation
- Synchronizer: `sig_in` passes through 2 flops, `s1` then `s2`. A third flop `s3` holds the previous `s2`. `rise` = `s2 & ~s3`.
- States: IDLE and MEASURE.
- IDLE:
  - `cnt` = 0, `hi_cnt` = 0.
  - On `rise` with `en` = 1: `cnt` <= 1, `hi_cnt` <= 1, go to MEASURE.
- MEASURE, no `rise`:
  - `cnt` <= `cnt` + 1.
  - `hi_cnt` <= `hi_cnt` + `s2`.
- MEASURE, on `rise`:
  - `period` <= `cnt`, `high_time` <= `hi_cnt`, `valid` <= 1.
  - `cnt` <= 1, `hi_cnt` <= 1.
  - Stay in MEASURE.
- Timeout: in MEASURE with `cnt` == `TIMEOUT` and no `rise`:
  - `timeout` <= 1, go to IDLE.
  - `period` and `high_time` keep their last values.
- `rise` coinciding with `cnt` == `TIMEOUT`: the rise wins. Publish `period` = `TIMEOUT` with `valid`; no `timeout` pulse.
- `en` low in any state: go to IDLE next cycle, no `valid` or `timeout`, result registers kept.
  - `en` re-asserted: the next `rise` starts a fresh measurement. The first period after enable is never published.
- Counters never wrap, because `TIMEOUT` < 2^`CNT_BIT`.
- `rst` (any cycle, including mid-measurement):
  - Synchronizer flops = 0, state = IDLE, `cnt` = `hi_cnt` = 0.
  - `period` = 0, `high_time` = 0, `valid` = 0, `timeout` = 0, `busy` = 0.

## Timing
- `sig_in` first sampled high at clock edge k: `rise` is active in the cycle after edge k+1. The resulting register updates (`valid`, `period`, or the IDLE→MEASURE entry) occur at edge k+2.
- Reported `period` = number of `clk` cycles between consecutive detected rises (P cycles apart → `period` = P).
- `valid` and `timeout` are exactly 1 cycle wide and never high together.
- Minimum measurable period: 2 cycles (alternating `s2`). Glitches shorter than 1 cycle may be missed; no filtering is done.
- `busy` is registered and equals (state == MEASURE).

## Configuration
- `FREQ_METER_HIGH_EN` defined: `hi_cnt` logic is compiled in and `high_time` reports duty as described above.
- Not defined: no `hi_cnt` register; `high_time` is tied to 0. Period measurement and timing are unchanged.

## Test plan
- Reset mid-measure: `sig_in` period 10, `rst` pulsed after 25 cycles.
  - During `rst`: all outputs 0.
  - After release: first `valid` no earlier than 2 rises later, with `period` = 10.
- Steady wave: `sig_in` 5 cycles high, 5 low, `en` = 1.
  - From the second rise onward: `valid` every 10 cycles, `period` = 10.
  - `high_time` = 5 with macro, 0 without.
- Duty change: `sig_in` 3 high, 13 low → `period` = 16, `high_time` = 3. Then switch to 12 high, 4 low → the next valid gives `period` = 16, `high_time` = 12.
- Timeout: `TIMEOUT` = 100, `sig_in` held 0 after one rise.
  - `timeout` pulses once, 100 cycles after the rise was registered.
  - State returns to IDLE, `busy` = 0, `period` unchanged, no `valid`.
- Boundary: `TIMEOUT` = 20, `sig_in` period exactly 20 → `valid` with `period` = 20, no `timeout`. Period 21 → `timeout` only.
- Enable gating: drop `en` mid-period of a 10-cycle wave for 30 cycles.
  - No `valid` while `en` is low, nor on the first rise after it returns high.
  - Next `valid` reports `period` = 10.
